// File: rtl/int_ctrl_if.sv
// Bus bundle between the interrupt controller and its neighbours
// (interrupt sources, pipeline control and the CSR file).
// The master side is the surrounding system; the slave side is int_ctrl.
interface int_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Interrupt sources
    logic              timer_irq_i;
    logic              ext_irq_i;
    // Pipeline control
    logic [ADDR_W-1:0] pc_i;
    logic              jump_we_i;
    logic [5:0]        stall_i;
    logic              mret_i;
    // CSR read side
    logic [DATA_W-1:0] mstatus_i;
    logic [DATA_W-1:0] mie_i;
    logic [DATA_W-1:0] mtvec_i;
    logic [DATA_W-1:0] mepc_i;
    // Redirect request to pipeline control
    logic              int_en_o;
    logic [ADDR_W-1:0] isr_pc_o;
    // CSR write port
    logic              csr_we_o;
    logic [11:0]       csr_waddr_o;
    logic [DATA_W-1:0] csr_wdata_o;
    logic              busy_o;

    modport master (
        output timer_irq_i, ext_irq_i, pc_i, jump_we_i, stall_i, mret_i,
        output mstatus_i, mie_i, mtvec_i, mepc_i,
        input  int_en_o, isr_pc_o, csr_we_o, csr_waddr_o, csr_wdata_o, busy_o
    );

    modport slave (
        input  timer_irq_i, ext_irq_i, pc_i, jump_we_i, stall_i, mret_i,
        input  mstatus_i, mie_i, mtvec_i, mepc_i,
        output int_en_o, isr_pc_o, csr_we_o, csr_waddr_o, csr_wdata_o, busy_o
    );
endinterface

// File: rtl/int_ctrl.sv
// Machine-mode interrupt controller.
// Takes a pending timer/external interrupt, writes mepc, mcause and mstatus
// through the CSR write port over three cycles, then requests a flush and
// redirect to the trap vector. On mret it restores mstatus and redirects to
// mepc. All outputs are registered and change together with the state.
// Optional build macro: INT_CTRL_VECTORED_EN (vectored mtvec mode).
module int_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic        clk_i,
    input logic        rst_i,
    int_ctrl_if.slave  bus
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [DATA_W-1:0] CAUSE_EXT   = DATA_W'(32'h8000_000B);
    localparam logic [DATA_W-1:0] CAUSE_TIMER = DATA_W'(32'h8000_0007);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        SAVE_STATUS,
        ENTER,
        IN_ISR,
        RET
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] cause_q;

    logic              int_en_q;
    logic [ADDR_W-1:0] isr_pc_q;
    logic              csr_we_q;
    logic [11:0]       csr_waddr_q;
    logic [DATA_W-1:0] csr_wdata_q;
    logic              busy_q;

    logic              ext_pend;
    logic              tmr_pend;
    logic              take;
    logic [DATA_W-1:0] cause_sel;
    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] save_status;
    logic [DATA_W-1:0] ret_status;
    logic [ADDR_W-1:0] vec_base;
    logic [ADDR_W-1:0] vec_target;

    // Pending/take decision and the data words the sequence writes out.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ext_pend  = bus.ext_irq_i & bus.mie_i[11];
        tmr_pend  = bus.timer_irq_i & bus.mie_i[7];
        take      = (ext_pend | tmr_pend) & bus.mstatus_i[3]
                    & ~bus.jump_we_i & (bus.stall_i == 6'd0);
        cause_sel = ext_pend ? CAUSE_EXT : CAUSE_TIMER;

        pc_ext                = '0;
        pc_ext[ADDR_W-1:0]    = bus.pc_i;

        // Trap entry: MPIE <- MIE, MIE <- 0.
        save_status    = bus.mstatus_i;
        save_status[7] = bus.mstatus_i[3];
        save_status[3] = 1'b0;

        // Trap return: MIE <- MPIE, MPIE <- 1.
        ret_status     = bus.mstatus_i;
        ret_status[3]  = bus.mstatus_i[7];
        ret_status[7]  = 1'b1;
    end

    // Trap vector target from mtvec and the latched cause.
    always_comb begin
        vec_base   = {bus.mtvec_i[ADDR_W-1:2], 2'b00};
        vec_target = vec_base;
`ifdef INT_CTRL_VECTORED_EN
        if (bus.mtvec_i[1:0] == 2'b01) begin
            vec_target = vec_base + {{(ADDR_W-6){1'b0}}, cause_q[3:0], 2'b00};
        end
`endif
    end

    // Controller FSM; outputs are registered alongside the next state.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous and clears every output register, so a
        // sequence cut short by reset can never leave a stray CSR write behind.
        if (rst_i) begin
            state       <= IDLE;
            cause_q     <= '0;
            int_en_q    <= 1'b0;
            isr_pc_q    <= '0;
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the
            // defaults below are overridden by the state that produces an output.
            int_en_q    <= 1'b0;
            isr_pc_q    <= '0;
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            busy_q      <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.mret_i) begin
                        state       <= RET;
                        csr_we_q    <= 1'b1;
                        csr_waddr_q <= CSR_MSTATUS;
                        csr_wdata_q <= ret_status;
                        int_en_q    <= 1'b1;
                        isr_pc_q    <= bus.mepc_i[ADDR_W-1:0];
                        busy_q      <= 1'b1;
                    end else if (take) begin
                        state       <= SAVE_EPC;
                        cause_q     <= cause_sel;
                        csr_we_q    <= 1'b1;
                        csr_waddr_q <= CSR_MEPC;
                        csr_wdata_q <= pc_ext;
                        busy_q      <= 1'b1;
                    end
                end
                SAVE_EPC: begin
                    state       <= SAVE_CAUSE;
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= CSR_MCAUSE;
                    csr_wdata_q <= cause_q;
                    busy_q      <= 1'b1;
                end
                SAVE_CAUSE: begin
                    state       <= SAVE_STATUS;
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= CSR_MSTATUS;
                    csr_wdata_q <= save_status;
                    busy_q      <= 1'b1;
                end
                SAVE_STATUS: begin
                    state    <= ENTER;
                    int_en_q <= 1'b1;
                    isr_pc_q <= vec_target;
                    busy_q   <= 1'b1;
                end
                ENTER: begin
                    // mret here belongs to a flushed instruction and is dropped.
                    state <= IN_ISR;
                end
                IN_ISR: begin
                    if (bus.mret_i) begin
                        state       <= RET;
                        csr_we_q    <= 1'b1;
                        csr_waddr_q <= CSR_MSTATUS;
                        csr_wdata_q <= ret_status;
                        int_en_q    <= 1'b1;
                        isr_pc_q    <= bus.mepc_i[ADDR_W-1:0];
                        busy_q      <= 1'b1;
                    end
                end
                RET: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.int_en_o    = int_en_q;
    assign bus.isr_pc_o    = isr_pc_q;
    assign bus.csr_we_o    = csr_we_q;
    assign bus.csr_waddr_o = csr_waddr_q;
    assign bus.csr_wdata_o = csr_wdata_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl. A spec-level model describes what each
// cycle of a trap entry / return should look like on the outputs; scenarios
// drive randomized traps, deferral, masking, mret and mid-sequence reset.
// Build with INT_CTRL_VECTORED_EN defined to cover the vectored mtvec mode.
module tb_int_ctrl;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        en;
        logic [31:0] pc;
        logic        busy;
    } out_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    int_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model (spec level) ----------------
    function automatic out_t m_quiet();
        return '0;
    endfunction

    function automatic out_t m_csr(input logic [11:0] addr, input logic [31:0] data);
        out_t o = '0;
        o.we = 1'b1; o.addr = addr; o.data = data; o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t m_redirect(input logic [31:0] pc);
        out_t o = '0;
        o.en = 1'b1; o.pc = pc; o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t m_ret(input logic [31:0] ms, input logic [31:0] mepc);
        out_t o = '0;
        o.we   = 1'b1;
        o.addr = 12'h300;
        o.data = (ms & ~32'h88) | 32'h80 | (((ms >> 7) & 32'h1) << 3);
        o.en   = 1'b1;
        o.pc   = mepc;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic logic [31:0] m_cause(input logic t, input logic e, input logic [31:0] mie);
        if (e && mie[11]) return 32'h8000_000B;
        return 32'h8000_0007;
    endfunction

    function automatic logic [31:0] m_vector(input logic [31:0] mtvec, input logic [31:0] cause);
        logic [31:0] base = mtvec & ~32'h3;
`ifdef INT_CTRL_VECTORED_EN
        if ((mtvec & 32'h3) == 32'h1) return base + 4 * (cause & 32'hF);
`endif
        return base;
    endfunction

    function automatic logic [31:0] m_saved_status(input logic [31:0] ms);
        return (ms & ~32'h88) | (((ms >> 3) & 32'h1) << 7);
    endfunction

    function automatic out_t obs();
        out_t o;
        o.we = bus.csr_we_o; o.addr = bus.csr_waddr_o; o.data = bus.csr_wdata_o;
        o.en = bus.int_en_o; o.pc = bus.isr_pc_o; o.busy = bus.busy_o;
        return o;
    endfunction

    // One clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.timer_irq_i = 0; bus.ext_irq_i = 0; bus.pc_i = '0; bus.jump_we_i = 0;
        bus.stall_i = '0; bus.mret_i = 0; bus.mstatus_i = '0; bus.mie_i = '0;
        bus.mtvec_i = '0; bus.mepc_i = '0;
    endtask

    // Drive a trap that is takeable this cycle and follow it into IN_ISR.
    // With noise set, the source drops and mret pulses during SAVE_*/ENTER.
    task automatic do_trap(input string tag, input logic [31:0] pc, input logic [31:0] mtvec,
                           input logic [31:0] ms, input logic [31:0] mie,
                           input logic t, input logic e, input logic noise);
        out_t got, exp;
        logic [31:0] cause = m_cause(t, e, mie);
        bus.pc_i = pc; bus.mtvec_i = mtvec; bus.mstatus_i = ms; bus.mie_i = mie;
        bus.timer_irq_i = t; bus.ext_irq_i = e; bus.jump_we_i = 0; bus.stall_i = '0;
        bus.mret_i = 0;
        step();
        got = obs(); exp = m_csr(12'h341, pc); checks++;
        if (got !== exp) begin errors++; $display("FAIL %s mepc_write got %p want %p", tag, got, exp); end
        bus.pc_i = $urandom;
        if (noise) begin bus.timer_irq_i = 0; bus.ext_irq_i = 0; bus.mret_i = 1; end
        step();
        got = obs(); exp = m_csr(12'h342, cause); checks++;
        if (got !== exp) begin errors++; $display("FAIL %s mcause_write got %p want %p", tag, got, exp); end
        step();
        got = obs(); exp = m_csr(12'h300, m_saved_status(ms)); checks++;
        if (got !== exp) begin errors++; $display("FAIL %s mstatus_write got %p want %p", tag, got, exp); end
        step();
        got = obs(); exp = m_redirect(m_vector(mtvec, cause)); checks++;
        if (got !== exp) begin errors++; $display("FAIL %s enter got %p want %p", tag, got, exp); end
        bus.mret_i = 0; bus.timer_irq_i = 1; bus.ext_irq_i = 1; bus.mie_i = 32'h880;
        for (int i = 0; i < 3; i++) begin
            step();
            got = obs(); exp = m_quiet(); checks++;
            if (got !== exp) begin errors++; $display("FAIL %s in_isr[%0d] got %p want %p", tag, i, got, exp); end
        end
    endtask

    // Pulse mret (from IN_ISR or IDLE) and check RET followed by quiet IDLE.
    task automatic do_ret(input string tag, input logic [31:0] ms, input logic [31:0] mepc);
        out_t got, exp;
        bus.timer_irq_i = 0; bus.ext_irq_i = 0;
        bus.mstatus_i = ms; bus.mepc_i = mepc; bus.mret_i = 1;
        step();
        got = obs(); exp = m_ret(ms, mepc); checks++;
        if (got !== exp) begin errors++; $display("FAIL %s ret got %p want %p", tag, got, exp); end
        bus.mret_i = 0;
        step();
        got = obs(); exp = m_quiet(); checks++;
        if (got !== exp) begin errors++; $display("FAIL %s after_ret got %p want %p", tag, got, exp); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        out_t got;
        rst_i = 1; idle_inputs();
        step(); step();
        got = obs(); checks++;
        if (got !== m_quiet()) begin errors++; $display("FAIL reset_outputs got %p want %p", got, m_quiet()); end
        rst_i = 0;
        step();
        got = obs(); checks++;
        if (got !== m_quiet()) begin errors++; $display("FAIL idle_after_reset got %p want %p", got, m_quiet()); end
    endtask

    task automatic test_timer_take();
        do_trap("timer_take", 32'h40, 32'h100, 32'h8, 32'h80, 1'b1, 1'b0, 1'b0);
        do_ret("timer_mret", 32'h80, 32'h44);
    endtask

    task automatic test_priority();
        do_trap("priority", 32'h1234, 32'h101, 32'h8, 32'h880, 1'b1, 1'b1, 1'b0);
        do_ret("priority_mret", 32'h80, 32'h1234);
        // External line high but masked: the timer wins.
        do_trap("ext_masked", 32'h2000, 32'h201, 32'h8, 32'h80, 1'b1, 1'b1, 1'b0);
        do_ret("ext_masked_mret", 32'h80, 32'h2000);
    endtask

    task automatic test_random_traps();
        for (int n = 0; n < 10; n++) begin
            int src = $urandom_range(0, 2);
            logic t = (src != 1);
            logic e = (src != 0);
            logic [31:0] en_bits = (src == 0) ? 32'h80 : (src == 1) ? 32'h800
                                 : ($urandom_range(0, 2) == 0 ? 32'h80
                                    : ($urandom_range(0, 1) == 0 ? 32'h800 : 32'h880));
            logic [31:0] mie   = ($urandom & ~32'h880) | en_bits;
            logic [31:0] ms    = $urandom | 32'h8;
            logic [31:0] mtvec = $urandom;
            logic [31:0] pc    = $urandom & ~32'h1;
            do_trap($sformatf("rand%0d", n), pc, mtvec, ms, mie, t, e, 1'($urandom_range(0, 1)));
            do_ret($sformatf("rand%0d_mret", n), $urandom, $urandom);
        end
    endtask

    task automatic test_deferral();
        out_t got;
        bus.mtvec_i = 32'h300; bus.mstatus_i = 32'h8; bus.mie_i = 32'h80;
        bus.timer_irq_i = 1; bus.ext_irq_i = 0; bus.mret_i = 0;
        for (int i = 0; i < 5; i++) begin
            bus.pc_i = $urandom;
            bus.jump_we_i = (i < 2);
            bus.stall_i = (i == 2) ? 6'b000111 : (i < 2 ? 6'd0 : 6'(1 << $urandom_range(0, 5)));
            step();
            got = obs(); checks++;
            if (got !== m_quiet()) begin errors++; $display("FAIL defer[%0d] got %p want %p", i, got, m_quiet()); end
        end
        do_trap("defer_take", 32'h7770, 32'h300, 32'h8, 32'h80, 1'b1, 1'b0, 1'b0);
        do_ret("defer_mret", 32'h80, 32'h7770);
    endtask

    task automatic test_masking();
        out_t got;
        bus.jump_we_i = 0; bus.stall_i = '0; bus.mret_i = 0; bus.mtvec_i = 32'h100;
        for (int i = 0; i < 20; i++) begin
            bus.pc_i = $urandom;
            bus.timer_irq_i = 1;
            bus.ext_irq_i = 1'($urandom_range(0, 1));
            if (i % 2 == 0) begin
                bus.mstatus_i = $urandom & ~32'h8;
                bus.mie_i = $urandom | 32'h880;
            end else begin
                bus.mstatus_i = $urandom | 32'h8;
                bus.mie_i = $urandom & ~32'h880;
            end
            step();
            got = obs(); checks++;
            if (got !== m_quiet()) begin errors++; $display("FAIL mask[%0d] got %p want %p", i, got, m_quiet()); end
        end
        bus.timer_irq_i = 0; bus.ext_irq_i = 0;
    endtask

    task automatic test_mret_idle();
        do_ret("mret_idle", 32'h80, 32'h44);
        do_ret("mret_idle_mpie0", 32'h0000_1800, 32'h8888);
    endtask

    task automatic test_reset_mid();
        out_t got, exp;
        bus.pc_i = 32'h500; bus.mtvec_i = 32'h100; bus.mstatus_i = 32'h8; bus.mie_i = 32'h80;
        bus.timer_irq_i = 1; bus.ext_irq_i = 0; bus.jump_we_i = 0; bus.stall_i = '0; bus.mret_i = 0;
        step();
        got = obs(); exp = m_csr(12'h341, 32'h500); checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_mid_epc got %p want %p", got, exp); end
        step();
        got = obs(); exp = m_csr(12'h342, 32'h8000_0007); checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_mid_cause got %p want %p", got, exp); end
        rst_i = 1;
        step();
        got = obs(); checks++;
        if (got !== m_quiet()) begin errors++; $display("FAIL rst_mid_abort got %p want %p", got, m_quiet()); end
        rst_i = 0;
        do_trap("rst_restart", 32'h600, 32'h100, 32'h8, 32'h80, 1'b1, 1'b0, 1'b0);
        do_ret("rst_restart_mret", 32'h80, 32'h600);
    endtask

    initial begin
        test_reset();
        test_timer_take();
        test_priority();
        test_deferral();
        test_masking();
        test_mret_idle();
        test_random_traps();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Machine-mode interrupt controller.
- Sits between the timer/external interrupt sources, the CSR file and the pipeline control block.
- Consumes the current PC from pipeline control, saves trap state into mepc/mcause/mstatus via the CSR write port, then requests a pipeline-wide flush and redirect to the trap vector.
- On mret it restores mstatus and redirects back to mepc.

Parameters:
- ADDR_W, 32, width of PC/address buses.
- DATA_W, 32, width of CSR data buses.

Ports:
- clk_i  in  1  clock; all state updates on posedge clk_i.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- timer_irq_i  in  1  level timer interrupt (hwtimer).
- ext_irq_i  in  1  level external interrupt.
- pc_i  in  ADDR_W  PC of the oldest valid instruction, from pipeline control.
- jump_we_i  in  1  branch/jump being resolved in EXE this cycle.
- stall_i  in  6  pipeline stall vector from pipeline control.
- mret_i  in  1  mret executing in EXE (single-cycle pulse).
- mstatus_i  in  DATA_W  current mstatus (MIE bit3, MPIE bit7).
- mie_i  in  DATA_W  current mie (MTIE bit7, MEIE bit11).
- mtvec_i  in  DATA_W  current mtvec.
- mepc_i  in  DATA_W  current mepc.
- int_en_o  out  1  one-cycle flush-all + redirect request.
- isr_pc_o  out  ADDR_W  redirect target, valid while int_en_o=1, else 0.
- csr_we_o  out  1  CSR write strobe.
- csr_waddr_o  out  12  CSR address: 0x341 mepc, 0x342 mcause, 0x300 mstatus.
- csr_wdata_o  out  DATA_W  CSR write data.
- busy_o  out  1  high in every state except IDLE and IN_ISR.

Behaviour:
- Reset: state=IDLE; all outputs 0; latched cause/pc cleared. Reset in any state aborts the sequence immediately; no partial CSR write is issued after reset.
- Pending: ext_pend = ext_irq_i & mie_i[11]; tmr_pend = timer_irq_i & mie_i[7]. Priority is external over timer. Cause codes: ext 0x8000000B, timer 0x80000007.
- States:
  - IDLE: take the trap when (ext_pend|tmr_pend) & mstatus_i[3] & !jump_we_i & (stall_i==0). On take, latch pc_i and the cause, then go to SAVE_EPC. If jump_we_i or any stall bit is set, defer; re-evaluate next cycle. If mret_i is asserted in IDLE, go to RET.
  - SAVE_EPC: csr_we_o=1, waddr 0x341, wdata = latched pc (zero-extended). Next: SAVE_CAUSE.
  - SAVE_CAUSE: csr_we_o=1, waddr 0x342, wdata = latched cause. Next: SAVE_STATUS.
  - SAVE_STATUS: csr_we_o=1, waddr 0x300, wdata = mstatus_i with bit7=mstatus_i[3] and bit3=0. Next: ENTER.
  - ENTER: int_en_o=1, isr_pc_o = vector target (see Optional Feature). Next: IN_ISR.
  - IN_ISR: outputs idle; wait for mret_i; on mret_i go to RET. Interrupt sources are ignored here.
  - RET: csr_we_o=1, waddr 0x300, wdata = mstatus_i with bit3=mstatus_i[7] and bit7=1; int_en_o=1; isr_pc_o = mepc_i[ADDR_W-1:0]. Next: IDLE.
- Latency: trap taken in cycle N gives CSR writes in N+1..N+3 and int_en_o in N+4. Total is 4 cycles from take to redirect.
- The interrupt source deasserting during SAVE_* does not abort: the sequence completes with the latched cause.
- mret_i during SAVE_* or ENTER is ignored (the pipeline is flushed by ENTER).
- At most one CSR write per cycle. csr_waddr_o/csr_wdata_o are 0 when csr_we_o=0.
- The interrupt being re-taken after RET requires mstatus MIE restored (visible from the cycle after RET).

Optional Feature:
- Macro INT_CTRL_VECTORED_EN.
- Defined: if mtvec_i[1:0]==2'b01, isr_pc_o = {mtvec_i[ADDR_W-1:2],2'b00} + 4*cause[3:0] (ext gives base+0x2C, timer gives base+0x1C). Any other mode uses the base only.
- Undefined: isr_pc_o = {mtvec_i[ADDR_W-1:2],2'b00} regardless of mode bits.

Test Plan:
- Timer take: mtvec=0x100, mie=0x80, mstatus=0x8, pc_i=0x40, timer_irq_i=1 at cycle N. Expect:
  - N+1 write 0x341 data 0x40
  - N+2 write 0x342 data 0x80000007
  - N+3 write 0x300 data 0x80
  - N+4 int_en_o=1, isr_pc_o=0x100
  - then IN_ISR with busy_o=0
- Priority: ext and timer both high, mie=0x880 → mcause write 0x8000000B. With INT_CTRL_VECTORED_EN and mtvec=0x101 → isr_pc_o=0x12C.
- Deferral: irq pending with jump_we_i=1 for 2 cycles, then stall_i=6'b000111 for 1 cycle → no csr_we_o until the first cycle with both clear. mepc equals pc_i of that cycle.
- Masking: mstatus MIE=0 or mie=0 with timer_irq_i=1 for 20 cycles → no CSR write, int_en_o stays 0.
- mret: in IN_ISR with mstatus=0x80, mepc=0x44, pulse mret_i → next cycle write 0x300 data 0x88, int_en_o=1, isr_pc_o=0x44, then IDLE.
- Reset mid-sequence: rst_i=1 during SAVE_CAUSE → next cycle all outputs 0, state IDLE, no SAVE_STATUS write. After release with irq still high, the full sequence restarts from SAVE_EPC.
